uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg / uart_rx
//
// Purpose: 8N1 UART receiver. The serial input is brought into the clock
// domain with a two-flop synchronizer. A five-state FSM then finds the
// falling edge of the start bit and re-checks the line at mid-bit. Each data
// bit (LSB first) is sampled one full bit period after the previous sample,
// and the stop bit is checked the same way.
//
// Ports:
//   i_Clock         system clock, all state changes on its rising edge
//   i_Rst_n         asynchronous active-low reset
//   i_Rx_Serial     asynchronous serial line, idle high
//   o_Rx_DV         one-cycle strobe: o_Rx_Byte carries a new byte
//   o_Rx_Byte       last correctly framed byte, held between strobes
//   o_Rx_Frame_Err  one-cycle strobe: stop bit was sampled low
//   o_Rx_Active     high while in START_BIT, DATA_BITS or STOP_BIT
//
// Output handshake: o_Rx_DV is a valid-only strobe with no ready. It is high
// for exactly one cycle per good frame, and o_Rx_Byte is stable from that
// cycle until the next strobe. The consumer must take the byte whenever
// o_Rx_DV is high, because there is no back-pressure. o_Rx_Frame_Err follows
// the same one-cycle rule, and the two strobes are mutually exclusive.
// ---------------------------------------------------------------------------
package uart_rx_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } state_t;
endpackage

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // Start bit is re-checked at its middle so that every later sample
  // falls near the middle of its bit as well.
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Synchronizer flops reset to the idle level, so releasing reset can
  // never look like a start-bit edge.
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;
  logic rx_s;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    rx_meta_d = i_Rx_Serial;
    rx_s_d    = rx_meta_q;
  end

  assign rx_s = rx_s_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      byte_q    <= 8'h00;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        if (!rx_s) state_d = START_BIT;
      end

      START_BIT: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          // Line back high at mid-bit means a glitch, so drop it silently.
          state_d = rx_s ? IDLE : DATA_BITS;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA_BITS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP_BIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      CLEANUP: begin
        // Wait for the line to go high again. A held-low line (break)
        // then gives one error pulse and cannot start a new frame.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = (state_q == START_BIT) ||
                          (state_q == DATA_BITS) ||
                          (state_q == STOP_BIT);

endmodule
